// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// morse_pkg : shared FSM states, glyph codes and Morse pattern lookup
// Rev 1.0
// ============================================================================
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    GAP    = 2'd2,
    DECODE = 2'd3
  } state_t;

  localparam logic [4:0] LETTER_ERR   = 5'd26;
  localparam logic [4:0] LETTER_BLANK = 5'd31;

  // Pattern holds the first symbol in the MSB of the used bits, dot=0 dash=1.
  function automatic logic [4:0] morse_lookup(input logic [2:0] len, input logic [3:0] pat);
    case ({len, pat})
      7'b010_0001: return 5'd0;   // A .-
      7'b100_1000: return 5'd1;   // B -...
      7'b100_1010: return 5'd2;   // C -.-.
      7'b011_0100: return 5'd3;   // D -..
      7'b001_0000: return 5'd4;   // E .
      7'b100_0010: return 5'd5;   // F ..-.
      7'b011_0110: return 5'd6;   // G --.
      7'b100_0000: return 5'd7;   // H ....
      7'b010_0000: return 5'd8;   // I ..
      7'b100_0111: return 5'd9;   // J .---
      7'b011_0101: return 5'd10;  // K -.-
      7'b100_0100: return 5'd11;  // L .-..
      7'b010_0011: return 5'd12;  // M --
      7'b010_0010: return 5'd13;  // N -.
      7'b011_0111: return 5'd14;  // O ---
      7'b100_0110: return 5'd15;  // P .--.
      7'b100_1101: return 5'd16;  // Q --.-
      7'b011_0010: return 5'd17;  // R .-.
      7'b011_0000: return 5'd18;  // S ...
      7'b001_0001: return 5'd19;  // T -
      7'b011_0001: return 5'd20;  // U ..-
      7'b100_0001: return 5'd21;  // V ...-
      7'b011_0011: return 5'd22;  // W .--
      7'b100_1001: return 5'd23;  // X -..-
      7'b100_1011: return 5'd24;  // Y -.--
      7'b100_1100: return 5'd25;  // Z --..
      default:     return LETTER_ERR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : 2-flop synchronizer plus tick-based debouncer for the key
// Rev 1.0
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_tick,
  output logic o_level
);

  localparam int         CW     = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Any clock where the synced key agrees with the held level restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == c_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// morse_key_decoder : times debounced key presses/gaps and decodes A..Z index
// Rev 1.0
// ============================================================================
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int DOT_MAX_MS    = 200,
  parameter int LETTER_GAP_MS = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [4:0] letterNum,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       key_level
);

  localparam int          PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [10:0] c_DOT_MAX    = 11'(DOT_MAX_MS);
  localparam logic [10:0] c_GAP_LAST   = 11'(LETTER_GAP_MS - 1);
  localparam logic [10:0] c_DUR_SAT    = 11'h7FF;

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          w_level;
  logic          r_level_q;
  logic          w_rise;
  logic          w_fall;
  logic [10:0]   r_dur;
  logic [3:0]    r_pat;
  logic [2:0]    r_len;
  logic          r_ovf;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_shift;
  logic          w_decode;
  logic [4:0]    w_code;
  logic [4:0]    r_letter;
  logic          r_valid;
  logic          r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_presc <= '0;
    else if (r_presc == c_PRESC_LAST) r_presc <= '0;
    else                            r_presc <= r_presc + 1'b1;
  end

  assign w_tick = (r_presc == c_PRESC_LAST);

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key   (key_in),
    .i_tick  (w_tick),
    .o_level (w_level)
  );

  assign w_rise = w_level & ~r_level_q;
  assign w_fall = ~w_level & r_level_q;

  // Edges are seen one clock after the debounce tick, so they never share a cycle with a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_q <= 1'b0;
      r_dur     <= '0;
    end else begin
      r_level_q <= w_level;
      if (w_rise || w_fall)                r_dur <= '0;
      else if (w_tick && r_dur != c_DUR_SAT) r_dur <= r_dur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_decode    = 1'b0;
    case (r_state)
      IDLE:   if (w_rise) w_state_nxt = PRESS;
      PRESS:  if (w_fall) begin
                w_shift     = 1'b1;
                w_state_nxt = GAP;
              end
      GAP:    if (w_tick && r_dur == c_GAP_LAST) w_state_nxt = DECODE;
              else if (w_rise)                   w_state_nxt = PRESS;
      DECODE: begin
                w_decode    = 1'b1;
                w_state_nxt = IDLE;
              end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_code = r_ovf ? LETTER_ERR : morse_lookup(r_len, r_pat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat    <= '0;
      r_len    <= '0;
      r_ovf    <= 1'b0;
      r_letter <= LETTER_BLANK;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_shift) begin
        if (r_len == 3'd4) begin
          r_ovf <= 1'b1;
        end else begin
          r_pat <= {r_pat[2:0], (r_dur >= c_DOT_MAX)};
          r_len <= r_len + 1'b1;
        end
      end else if (w_decode) begin
        r_letter <= w_code;
        r_valid  <= 1'b1;
        r_err    <= (w_code == LETTER_ERR);
        r_pat    <= '0;
        r_len    <= '0;
        r_ovf    <= 1'b0;
      end
    end
  end

  assign letterNum    = r_letter;
  assign letter_valid = r_valid;
  assign letter_err   = r_err;
  assign key_level    = w_level;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// tb_morse_key_decoder : directed + random key sequences against a Morse-string model
// Rev 1.0
// ============================================================================
module tb_morse_key_decoder;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic [4:0] letterNum;
  logic       letter_valid;
  logic       letter_err;
  logic       key_level;

  int errors  = 0;
  int checks  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int v0, e0;

  string MORSE[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--.."};

  morse_key_decoder #(
    .TICK_DIV      (TD),
    .DEBOUNCE_MS   (2),
    .DOT_MAX_MS    (20),
    .LETTER_GAP_MS (60)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .letterNum    (letterNum),
    .letter_valid (letter_valid),
    .letter_err   (letter_err),
    .key_level    (key_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (letter_valid) n_valid++;
    if (letter_err)   n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int ticks);
    key_in = lvl;
    repeat (ticks * TD) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  task automatic expect_letter(input string tag, input int exp);
    check({tag, ".num"},   32'(letterNum), 32'(exp));
    check({tag, ".valid"}, 32'(n_valid - v0), 32'd1);
    check({tag, ".err"},   32'(n_err - e0), (exp == 26) ? 32'd1 : 32'd0);
  endtask

  // Reference: a letter is its Morse string; anything longer than 4 or unlisted is the error glyph.
  function automatic int ref_decode(input string s);
    if (s.len() == 0 || s.len() > 4) return 26;
    for (int k = 0; k < 26; k++)
      if (s == MORSE[k]) return k;
    return 26;
  endfunction

  task automatic play_random(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == "-") hold(1'b1, int'($urandom_range(35, 20)));
      else                  hold(1'b1, int'($urandom_range(19, 3)));
      if (i != s.len() - 1) hold(1'b0, int'($urandom_range(30, 3)));
    end
    hold(1'b0, int'($urandom_range(75, 65)));
  endtask

  task automatic play_fixed(input string s, input int dot, input int dash, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      hold(1'b1, (s.getc(i) == "-") ? dash : dot);
      if (i != s.len() - 1) hold(1'b0, gap);
    end
    hold(1'b0, 70);
  endtask

  initial begin
    string s;
    key_in = 1'b0;
    #1;
    do_reset();
    @(posedge clk); #1;
    check("rst.num",   32'(letterNum), 32'd31);
    check("rst.valid", 32'(letter_valid), 32'd0);
    check("rst.err",   32'(letter_err), 32'd0);
    check("rst.level", 32'(key_level), 32'd0);

    mark(); hold(1'b1, 5); hold(1'b0, 10); hold(1'b1, 30); hold(1'b0, 70);
    expect_letter("A", 0);

    mark(); play_fixed("-...", 5, 30, 10);  expect_letter("B", 1);
    mark(); play_fixed("----", 5, 30, 10);  expect_letter("four_dash", 26);
    mark(); play_fixed(".....", 5, 30, 10); expect_letter("five_dot", 26);

    mark();
    hold(1'b1, 1); hold(1'b0, 5);
    check("glitch_idle.level", 32'(key_level), 32'd0);
    hold(1'b1, 1); hold(1'b0, 70);
    check("glitch_idle.pulses", 32'(n_valid - v0), 32'd0);

    mark();
    hold(1'b1, 10); hold(1'b0, 1);
    check("glitch_press.level0", 32'(key_level), 32'd1);
    hold(1'b1, 15);
    check("glitch_press.level1", 32'(key_level), 32'd1);
    hold(1'b0, 70);
    expect_letter("glitch_press", 19);

    mark(); hold(1'b1, 20); hold(1'b0, 70);   expect_letter("press20", 19);
    mark(); hold(1'b1, 19); hold(1'b0, 70);   expect_letter("press19", 4);
    mark(); hold(1'b1, 2100); hold(1'b0, 70); expect_letter("saturate", 19);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        s = MORSE[$urandom_range(25, 0)];
      end else begin
        s = "";
        for (int j = 0; j < int'($urandom_range(5, 1)); j++)
          s = {s, ($urandom_range(1, 0) == 1) ? "-" : "."};
      end
      mark();
      play_random(s);
      expect_letter({"rand_", s}, ref_decode(s));
    end

    mark();
    hold(1'b1, 5); hold(1'b0, 10); hold(1'b1, 10);
    key_in = 1'b0;
    rst_n  = 1'b0;
    #2;
    check("midrst.num_async", 32'(letterNum), 32'd31);
    do_reset();
    @(posedge clk); #1;
    check("midrst.num",   32'(letterNum), 32'd31);
    check("midrst.level", 32'(key_level), 32'd0);
    hold(1'b0, 70);
    check("midrst.pulses", 32'(n_valid - v0), 32'd0);
    check("midrst.num_hold", 32'(letterNum), 32'd31);
    mark(); hold(1'b1, 5); hold(1'b0, 70);
    expect_letter("after_rst", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
